// File: rtl/taylor_pkg.sv
// rtl/taylor_pkg.sv - shared types, constants and 1/n! table for the Taylor-series control unit
package taylor_pkg;

  typedef enum logic [1:0] {
    MODE_EXP  = 2'd0,
    MODE_SIN  = 2'd1,
    MODE_COS  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ITER  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [31:0] FP_ONE    = 32'h3F80_0000;
  localparam logic [31:0] SIGN_MASK = 32'h8000_0000;

  // 1/n! for n = 0..19, FP32 round-to-nearest
  localparam logic [31:0] INV_FACT [0:19] = '{
    32'h3F800000, 32'h3F800000, 32'h3F000000, 32'h3E2AAAAB, 32'h3D2AAAAB,
    32'h3C088889, 32'h3AB60B61, 32'h39500D01, 32'h37D00D01, 32'h3638EF1D,
    32'h3493F27E, 32'h32D7322B, 32'h310F76C7, 32'h2F309231, 32'h2D49CBA5,
    32'h2B573F9F, 32'h29573F9F, 32'h274A963C, 32'h253413C3, 32'h2317A4DA
  };

  // Reserved encoding folds onto EXP so the rest of the design only sees three modes
  function automatic mode_e norm_mode(input logic [1:0] m);
    case (m)
      2'd1:    return MODE_SIN;
      2'd2:    return MODE_COS;
      default: return MODE_EXP;
    endcase
  endfunction

endpackage

// File: rtl/taylor_series_cu_if.sv
// rtl/taylor_series_cu_if.sv - request and datapath-control bundle of the Taylor-series control unit
interface taylor_series_cu_if #(
  parameter int DW = 32
);
  logic          start;
  logic [1:0]    mode;
  logic [DW-1:0] num;
  logic [DW-1:0] x;
  logic [DW-1:0] cf;
  logic [3:0]    k;
  logic          acc_clr;
  logic          acc_en;
  logic          pw_load;
  logic          pw_init_sel;
  logic          sq_en;
  logic          pw_en;
  logic          busy;
  logic          done;

  modport master (
    output start, mode, num,
    input  x, cf, k, acc_clr, acc_en, pw_load, pw_init_sel, sq_en, pw_en, busy, done
  );

  modport slave (
    input  start, mode, num,
    output x, cf, k, acc_clr, acc_en, pw_load, pw_init_sel, sq_en, pw_en, busy, done
  );
endinterface

// File: rtl/taylor_coef_rom.sv
// rtl/taylor_coef_rom.sv - combinational (mode, k) -> signed FP32 series coefficient
module taylor_coef_rom
  import taylor_pkg::*;
(
  input  mode_e       mode_i,
  input  logic [3:0]  k_i,
  output logic [31:0] cf_o
);

  logic [4:0] idx;
  logic       neg;

  always_comb begin
    idx = {1'b0, k_i};
    neg = 1'b0;
    case (mode_i)
      MODE_SIN: begin
        idx = {k_i, 1'b1};
        neg = k_i[0];
      end
      MODE_COS: begin
        idx = {k_i, 1'b0};
        neg = k_i[0];
      end
      default: begin
        idx = {1'b0, k_i};
        neg = 1'b0;
      end
    endcase

    cf_o = (idx <= 5'd19) ? INV_FACT[idx] : 32'h0;
    // Alternating series terms only flip the sign bit; magnitude comes straight from the table
    if (neg) begin
      cf_o = cf_o ^ SIGN_MASK;
    end
  end

endmodule

// File: rtl/taylor_series_cu.sv
// rtl/taylor_series_cu.sv - sequences the multiply/accumulate datapath through N_TERMS series terms
module taylor_series_cu
  import taylor_pkg::*;
#(
  parameter int N_TERMS   = 10,
  parameter int DRAIN_LAT = 1,
  parameter int DW        = 32
) (
  input  logic                 clk,
  input  logic                 res,
  taylor_series_cu_if.slave    bus
);

  localparam logic [3:0] K_LAST     = 4'(N_TERMS - 1);
  localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_LAT);

  state_e        state_q;
  mode_e         mode_q;
  mode_e         mode_d;
  logic [DW-1:0] x_q;
  logic [DW-1:0] cf_q;
  logic [31:0]   cf_d;
  logic [3:0]    k_q;
  logic [3:0]    k_d;
  logic [2:0]    drain_q;
  logic          acc_clr_q;
  logic          acc_en_q;
  logic          pw_load_q;
  logic          pw_init_sel_q;
  logic          sq_en_q;
  logic          pw_en_q;
  logic          busy_q;
  logic          done_q;

  assign mode_d = norm_mode(bus.mode);
  // Coefficient is looked up for the term about to be presented, so it lands in cf_q with its k
  assign k_d    = (state_q == LOAD) ? 4'd0 : k_q + 4'd1;

  taylor_coef_rom u_coef_rom (
    .mode_i (mode_q),
    .k_i    (k_d),
    .cf_o   (cf_d)
  );

  always_ff @(posedge clk) begin
    if (res) begin
      state_q       <= IDLE;
      mode_q        <= MODE_EXP;
      x_q           <= '0;
      cf_q          <= '0;
      k_q           <= '0;
      drain_q       <= '0;
      acc_clr_q     <= 1'b0;
      acc_en_q      <= 1'b0;
      pw_load_q     <= 1'b0;
      pw_init_sel_q <= 1'b0;
      sq_en_q       <= 1'b0;
      pw_en_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      cf_q          <= '0;
      k_q           <= '0;
      acc_clr_q     <= 1'b0;
      acc_en_q      <= 1'b0;
      pw_load_q     <= 1'b0;
      pw_init_sel_q <= 1'b0;
      sq_en_q       <= 1'b0;
      pw_en_q       <= 1'b0;
      done_q        <= 1'b0;

      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q       <= LOAD;
            x_q           <= bus.num;
            mode_q        <= mode_d;
            busy_q        <= 1'b1;
            acc_clr_q     <= 1'b1;
            pw_load_q     <= 1'b1;
            pw_init_sel_q <= (mode_d == MODE_SIN);
            sq_en_q       <= (mode_d != MODE_EXP);
          end
        end

        LOAD: begin
          state_q  <= ITER;
          k_q      <= k_d;
          cf_q     <= cf_d;
          acc_en_q <= 1'b1;
          pw_en_q  <= (k_d != K_LAST);
        end

        ITER: begin
          if (k_q == K_LAST) begin
            if (DRAIN_LAT == 0) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= DRAIN;
              drain_q <= 3'd1;
            end
          end else begin
            k_q      <= k_d;
            cf_q     <= cf_d;
            acc_en_q <= 1'b1;
            pw_en_q  <= (k_d != K_LAST);
          end
        end

        DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + 3'd1;
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.x           = x_q;
  assign bus.cf          = cf_q;
  assign bus.k           = k_q;
  assign bus.acc_clr     = acc_clr_q;
  assign bus.acc_en      = acc_en_q;
  assign bus.pw_load     = pw_load_q;
  assign bus.pw_init_sel = pw_init_sel_q;
  assign bus.sq_en       = sq_en_q;
  assign bus.pw_en       = pw_en_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: doc/taylor_series_cu.md
Name: taylor_series_cu

Overview:
Parametrised control unit for the FP32 Taylor-series evaluator. It is the successor to the fixed 10-term exp-only controller. It sequences an external multiply/accumulate datapath (power register, squarer, accumulator) through a configurable number of terms. It adds exp/sin/cos mode selection, a start/busy/done handshake, and configurable pipeline drain.

Parameters:
N_TERMS, 10, number of series terms evaluated; legal range 2..10.
DRAIN_LAT, 1, cycles waited after last accumulate for datapath pipeline to settle; legal range 0..7.
DW, 32, data width (FP32 only; fixed coefficient encoding).

Ports:
clk  in  1  clock, all logic on rising edge
res  in  1  synchronous reset, active-high
start  in  1  request evaluation; accepted only in IDLE
mode  in  2  0=EXP, 1=SIN, 2=COS, 3=reserved (treated as EXP)
num  in  DW  FP32 operand, sampled with accepted start
x  out  DW  latched operand to datapath
cf  out  DW  FP32 coefficient for current term
k  out  4  current term index
acc_clr  out  1  clear accumulator
acc_en  out  1  accumulate cf*power
pw_load  out  1  load power register with init value
pw_init_sel  out  1  power init: 0=1.0, 1=x
sq_en  out  1  capture x*x into multiplicand register
pw_en  out  1  power <= power*multiplicand (x for EXP, x^2 for SIN/COS)
busy  out  1  evaluation in progress
done  out  1  one-cycle pulse, accumulator result valid

Behaviour:
- Reset (res=1 at an edge): state=IDLE; x=0, cf=0, k=0, all strobes=0, busy=0, done=0. Reset takes priority over start and over any state, including mid-operation. No done is issued for an aborted run.
- Timing reference: cycle c means c rising edges after the edge that samples an accepted start.
- IDLE: busy=0, all strobes 0, cf=0.
  - start=1 latches num into x and mode into mode_r, then moves to LOAD.
  - start in any other state is ignored; x and mode_r stay unchanged.
- LOAD (cycle 1): busy=1, acc_clr=1, pw_load=1.
  - pw_init_sel=1 iff mode_r=SIN.
  - sq_en=1 iff mode_r is SIN or COS.
  - Next state is ITER with k=0.
- ITER (cycles 2..N_TERMS+1): acc_en=1, cf=coef(mode_r,k).
  - pw_en=1 except on the final term.
  - k increments each cycle.
  - After k=N_TERMS-1, go to DRAIN, or straight to DONE if DRAIN_LAT=0.
- DRAIN: DRAIN_LAT cycles, all strobes 0, cf=0, busy=1.
- DONE (cycle N_TERMS+2+DRAIN_LAT): done=1 and busy=0 for exactly one cycle, then IDLE.
  - A start sampled during the DONE cycle is ignored; restart is possible from the following cycle.
- Coefficients (FP32, round-to-nearest), with F(n)=1/n!:
  - EXP: cf(k) = F(k).
  - SIN: cf(k) = F(2k+1) with sign bit set for odd k.
  - COS: cf(k) = F(2k) with sign bit set for odd k.
  - Sign is applied by XOR of bit 31; the magnitude table is never negated arithmetically.
- Outputs are registered (cf included); no combinational path from inputs to outputs.
- k, cf and the strobes hold 0 outside LOAD/ITER except as stated above.

Decomposition:
- Package taylor_pkg:
  - mode encodings MODE_EXP/SIN/COS.
  - FP_ONE = 3F800000, SIGN_MASK = 80000000.
  - INV_FACT[0..19] FP32 table, for example:
    - [0..4] = 3F800000, 3F800000, 3F000000, 3E2AAAAB, 3D2AAAAB
    - [5..9] = 3C088889, 3AB60B61, 39500D01, 37D00D01, 3638EF1D
    - remainder through 1/19!
  - state enum IDLE/LOAD/ITER/DRAIN/DONE.
- Sub-module taylor_coef_rom: combinational (mode, k) -> cf, using package table plus sign logic. The CU registers its output.

Test Plan:
- EXP: N_TERMS=10, DRAIN_LAT=1, num=3F800000, start in cycle 0:
  - cycle 1: acc_clr=1, pw_load=1, pw_init_sel=0, sq_en=0.
  - cf over cycles 2..11 = 3F800000, 3F800000, 3F000000, 3E2AAAAB, 3D2AAAAB, 3C088889, 3AB60B61, 39500D01, 37D00D01, 3638EF1D.
  - done=1 only in cycle 13; busy high in cycles 1..12.
- SIN, num=3F000000:
  - cycle 1: pw_init_sel=1, sq_en=1.
  - first cf values 3F800000, BE2AAAAB, 3C088889, B9500D01.
  - x=3F000000 throughout.
- COS: first cf values 3F800000, BF000000, 3D2AAAAB, BAB60B61; pw_init_sel=0, sq_en=1 in LOAD.
- Reset mid-run: assert res during ITER at k=4.
  - Next cycle: busy=0, cf=0, k=0, x=0, all strobes 0.
  - No done pulse.
  - A new start after reset completes normally.
- Start while busy / in DONE: pulse start with num=40000000 in cycle 5 and in the DONE cycle.
  - x stays at the original value; no extra run.
  - A start one cycle after DONE is accepted.
- Parametrisation: N_TERMS=2, DRAIN_LAT=0, mode=3:
  - behaves as EXP; cf = 3F800000, 3F800000 in cycles 2..3.
  - pw_en=1 in cycle 2 only; done in cycle 4.
